cr_huf_comp_ph_loader: RTL and testbench
========================================

Name: cr_huf_comp_ph_loader

Overview:
- Sequencer that loads one predetermined Huffman table set into the predet memories (PH long and short banks).
- Each load writes 22 long-table words, then 48 short-table words, for a single mem_id (0..NUM_TABLES-1).
- Input is a valid/ready word stream; output drives the two s_sm_predet_mem_intf-style write ports.
- Keeps a per-table valid bitmap and blocks a reload while any sequence still reads that table.

Parameters:
- NUM_TABLES, 10, number of predet table slots (mem_id range).
- LONG_WORDS, 22, long-bank words per table.
- SHRT_WORDS, 48, short-bank words per table.
- DATA_W, 60, table word width.

Ports:
- clk  input  1  core clock
- rst_n  input  1  asynchronous active-low reset
- ld_req  input  1  load request; held until ld_ack
- ld_mem_id  input  4  target table slot, sampled with ld_req
- ld_ack  output  1  one-cycle pulse when the request is accepted
- ld_abort  input  1  cancels the load in progress
- ld_data  input  DATA_W  table word
- ld_data_val  input  1  ld_data valid
- ld_data_rdy  output  1  loader accepts a word this cycle
- tbl_in_use  input  NUM_TABLES  bit i set while any seq_id references table i
- long_wr  output  1  long-bank write strobe
- long_mem_id  output  4  long-bank write table id
- long_addr  output  5  long-bank word index, 0..LONG_WORDS-1
- long_data  output  DATA_W  long-bank write data
- shrt_wr  output  1  short-bank write strobe
- shrt_mem_id  output  4  short-bank write table id
- shrt_addr  output  6  short-bank word index, 0..SHRT_WORDS-1
- shrt_data  output  DATA_W  short-bank write data
- tbl_valid  output  NUM_TABLES  table i loaded and usable
- ld_done  output  1  one-cycle pulse when a load completes
- ld_err  output  1  one-cycle pulse when a load is rejected or fails

Behaviour:
- Reset values: every output is 0; state is IDLE; counters are 0; tbl_valid is 0.
- All outputs are registered except ld_data_rdy, which decodes directly from the state register.
- States:
  - IDLE: on ld_req with ld_mem_id >= NUM_TABLES, pulse ld_ack and ld_err, write nothing, stay in IDLE. On ld_req with a legal id, pulse ld_ack, latch the id, clear tbl_valid[id] on the next edge, and go to WAIT_FREE.
  - WAIT_FREE: wait while tbl_in_use[id]=1, so a table is never overwritten under an active reader. Go to LONG once the bit is 0. Checked every cycle; no timeout.
  - LONG: ld_data_rdy=1. Each val&rdy beat writes long_addr = word count (0..21). After beat 21, the counter resets and the state moves to SHRT.
  - SHRT: same rules with shrt_addr 0..47. After beat 47, go to DONE (or CHK when the option is enabled).
  - DONE: set tbl_valid[id], pulse ld_done, return to IDLE. DONE lasts one cycle.
- Write latency: a beat accepted on edge N asserts the matching *_wr for exactly one cycle after edge N, with the captured data and address. Otherwise *_wr=0; data and address hold their last values.
- Only one of long_wr/shrt_wr is high in any cycle. Back-to-back beats give back-to-back writes with no bubble, including across the LONG->SHRT boundary.
- ld_abort:
  - In WAIT_FREE, LONG or SHRT: go to IDLE on the next edge, clear counters, pulse ld_err, leave tbl_valid[id]=0.
  - A beat presented in the same cycle as ld_abort is not accepted.
  - ld_abort in IDLE or DONE is ignored.
- ld_req outside IDLE is not acknowledged; it stays pending until the loader returns to IDLE.
- A reload of a valid id clears its valid bit at ack; other ids' bits are untouched.
- Reset mid-load: all state is lost, tbl_valid returns to 0, and no partial write is issued after reset deasserts.

Optional Feature:
- Macro: CR_HUF_COMP_PH_LD_CHKSUM_EN.
- Enabled:
  - The loader keeps a running DATA_W-bit XOR of all 70 table words.
  - After SHRT it enters CHK, with ld_data_rdy=1, and accepts one extra checksum word, which is never written to a bank.
  - Match: go to DONE.
  - Mismatch: pulse ld_err, leave tbl_valid[id]=0, go to IDLE.
- Disabled: no CHK state; SHRT goes directly to DONE.

Test Plan:
- Basic load: ld_req id=3, tbl_in_use=0, 70 beats with val always high and data = beat index -> ld_ack one cycle; long_wr on 22 consecutive cycles (addr 0..21); shrt_wr on 48 consecutive cycles (addr 0..47, data 22..69); ld_done once; tbl_valid=10'h008.
- Blocked table: tbl_valid[5]=1, tbl_in_use[5]=1, ld_req id=5 -> ack, tbl_valid[5]=0, ld_data_rdy=0 for 20 cycles; release in_use -> load completes and tbl_valid[5]=1.
- Illegal id: ld_req id=12 -> ld_ack and ld_err in the same cycle; no writes; state remains IDLE.
- Abort: id=7, abort after 30 beats (long done, short addr 7) -> ld_err; no further writes; tbl_valid[7]=0; a following load of id 7 succeeds with addr restarting at 0.
- Gapped stream: ld_data_val toggling 1,0,0,1 -> writes only on accepted beats; addresses contiguous; exactly 70 writes total.
- Chksum option: correct XOR word -> tbl_valid set; corrupted word (bit 0 flipped) -> ld_err and valid stays 0; macro off -> the 71st word is not accepted.

Source files
------------

// File: rtl/cr_huf_comp_ph_loader.sv
// ---------------------------------------------------------------------------
// cr_huf_comp_ph_loader
//
// Loads one predetermined Huffman table set into the predet memories. A load
// writes LONG_WORDS long-bank words and then SHRT_WORDS short-bank words for a
// single mem_id. A per-table valid bitmap is kept. A table is not overwritten
// while any sequence still reads it.
//
// Optional build macro: CR_HUF_COMP_PH_LD_CHKSUM_EN
//   When defined, a running XOR of all table words is compared against one
//   extra checksum word that follows the short-bank words. On a match the table
//   becomes valid. On a mismatch the load fails.
//
// Ports:
//   clk, rst_n          core clock, asynchronous active-low reset
//   ld_req/ld_mem_id    load request and target slot; ld_ack pulses on accept
//   ld_abort            cancels the load in progress
//   ld_data/_val/_rdy   table word stream (valid/ready)
//   tbl_in_use          per-table "still referenced by a sequence" bits
//   long_* / shrt_*     registered write ports of the long and short banks
//   tbl_valid           per-table loaded-and-usable bitmap
//   ld_done / ld_err    one-cycle completion / rejection-or-failure pulses
//
// FSM states:
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IDLE      | waiting for ld_req
//   WAIT_FREE | slot accepted; waiting for tbl_in_use[id] to clear
//   LONG      | accepting long-bank words, addr 0..LONG_WORDS-1
//   SHRT      | accepting short-bank words, addr 0..SHRT_WORDS-1
//   CHK       | (checksum build only) accepting the checksum word
//   DONE      | one cycle: mark table valid, pulse ld_done
// ---------------------------------------------------------------------------
module cr_huf_comp_ph_loader #(
  parameter int NUM_TABLES = 10,
  parameter int LONG_WORDS = 22,
  parameter int SHRT_WORDS = 48,
  parameter int DATA_W     = 60
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ld_req,
  input  logic [3:0]            ld_mem_id,
  output logic                  ld_ack,
  input  logic                  ld_abort,
  input  logic [DATA_W-1:0]     ld_data,
  input  logic                  ld_data_val,
  output logic                  ld_data_rdy,
  input  logic [NUM_TABLES-1:0] tbl_in_use,
  output logic                  long_wr,
  output logic [3:0]            long_mem_id,
  output logic [4:0]            long_addr,
  output logic [DATA_W-1:0]     long_data,
  output logic                  shrt_wr,
  output logic [3:0]            shrt_mem_id,
  output logic [5:0]            shrt_addr,
  output logic [DATA_W-1:0]     shrt_data,
  output logic [NUM_TABLES-1:0] tbl_valid,
  output logic                  ld_done,
  output logic                  ld_err
);

  localparam logic [4:0] NUM_TABLES_W = 5'(NUM_TABLES);
  localparam logic [5:0] LONG_LAST    = 6'(LONG_WORDS - 1);
  localparam logic [5:0] SHRT_LAST    = 6'(SHRT_WORDS - 1);

`ifdef CR_HUF_COMP_PH_LD_CHKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_FREE = 3'd1,
    S_LONG      = 3'd2,
    S_SHRT      = 3'd3,
    S_DONE      = 3'd4,
    S_CHK       = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_FREE = 3'd1,
    S_LONG      = 3'd2,
    S_SHRT      = 3'd3,
    S_DONE      = 3'd4
  } state_t;
`endif

  state_t                state_q, state_d;
  logic [3:0]            id_q, id_d;
  logic [5:0]            cnt_q, cnt_d;
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;
  logic                  done_q, done_d;
  logic                  long_wr_q, long_wr_d;
  logic [3:0]            long_mem_id_q, long_mem_id_d;
  logic [4:0]            long_addr_q, long_addr_d;
  logic [DATA_W-1:0]     long_data_q, long_data_d;
  logic                  shrt_wr_q, shrt_wr_d;
  logic [3:0]            shrt_mem_id_q, shrt_mem_id_d;
  logic [5:0]            shrt_addr_q, shrt_addr_d;
  logic [DATA_W-1:0]     shrt_data_q, shrt_data_d;
  logic [NUM_TABLES-1:0] tbl_valid_q, tbl_valid_d;
`ifdef CR_HUF_COMP_PH_LD_CHKSUM_EN
  logic [DATA_W-1:0]     xor_q, xor_d;
`endif

  logic rdy;
  logic beat;
  logic id_legal;

  // Ready is a pure state decode so the source sees it without a comb path
  // from its own valid.
  always_comb begin
    rdy = (state_q == S_LONG) || (state_q == S_SHRT);
`ifdef CR_HUF_COMP_PH_LD_CHKSUM_EN
    if (state_q == S_CHK) rdy = 1'b1;
`endif
  end

  // A word offered in the abort cycle is dropped, even though rdy is high.
  assign beat     = ld_data_val & rdy & ~ld_abort;
  assign id_legal = ({1'b0, ld_mem_id} < NUM_TABLES_W);

  always_comb begin
    state_d       = state_q;
    id_d          = id_q;
    cnt_d         = cnt_q;
    ack_d         = 1'b0;
    err_d         = 1'b0;
    done_d        = 1'b0;
    long_wr_d     = 1'b0;
    long_mem_id_d = long_mem_id_q;
    long_addr_d   = long_addr_q;
    long_data_d   = long_data_q;
    shrt_wr_d     = 1'b0;
    shrt_mem_id_d = shrt_mem_id_q;
    shrt_addr_d   = shrt_addr_q;
    shrt_data_d   = shrt_data_q;
    tbl_valid_d   = tbl_valid_q;
`ifdef CR_HUF_COMP_PH_LD_CHKSUM_EN
    xor_d         = xor_q;
`endif

    case (state_q)
      S_IDLE: begin
        // ack_q blocks a second acknowledge while the requester is still
        // dropping ld_req in the cycle it sees ld_ack.
        if (ld_req && !ack_q) begin
          ack_d = 1'b1;
          if (!id_legal) begin
            err_d = 1'b1;
          end else begin
            id_d                   = ld_mem_id;
            tbl_valid_d[ld_mem_id] = 1'b0;
            cnt_d                  = '0;
`ifdef CR_HUF_COMP_PH_LD_CHKSUM_EN
            xor_d                  = '0;
`endif
            state_d                = S_WAIT_FREE;
          end
        end
      end

      S_WAIT_FREE: begin
        if (ld_abort) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (!tbl_in_use[id_q]) begin
          state_d = S_LONG;
        end
      end

      S_LONG: begin
        if (ld_abort) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (beat) begin
          long_wr_d     = 1'b1;
          long_mem_id_d = id_q;
          long_addr_d   = cnt_q[4:0];
          long_data_d   = ld_data;
`ifdef CR_HUF_COMP_PH_LD_CHKSUM_EN
          xor_d         = xor_q ^ ld_data;
`endif
          if (cnt_q == LONG_LAST) begin
            cnt_d   = '0;
            state_d = S_SHRT;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end

      S_SHRT: begin
        if (ld_abort) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (beat) begin
          shrt_wr_d     = 1'b1;
          shrt_mem_id_d = id_q;
          shrt_addr_d   = cnt_q;
          shrt_data_d   = ld_data;
`ifdef CR_HUF_COMP_PH_LD_CHKSUM_EN
          xor_d         = xor_q ^ ld_data;
`endif
          if (cnt_q == SHRT_LAST) begin
            cnt_d   = '0;
`ifdef CR_HUF_COMP_PH_LD_CHKSUM_EN
            state_d = S_CHK;
`else
            state_d = S_DONE;
`endif
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end

`ifdef CR_HUF_COMP_PH_LD_CHKSUM_EN
      S_CHK: begin
        // The checksum word is compared only; it never reaches a bank.
        if (ld_abort) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (beat) begin
          if (ld_data == xor_q) begin
            state_d = S_DONE;
          end else begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
`endif

      S_DONE: begin
        tbl_valid_d[id_q] = 1'b1;
        done_d            = 1'b1;
        state_d           = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      id_q          <= '0;
      cnt_q         <= '0;
      ack_q         <= 1'b0;
      err_q         <= 1'b0;
      done_q        <= 1'b0;
      long_wr_q     <= 1'b0;
      long_mem_id_q <= '0;
      long_addr_q   <= '0;
      long_data_q   <= '0;
      shrt_wr_q     <= 1'b0;
      shrt_mem_id_q <= '0;
      shrt_addr_q   <= '0;
      shrt_data_q   <= '0;
      tbl_valid_q   <= '0;
`ifdef CR_HUF_COMP_PH_LD_CHKSUM_EN
      xor_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      id_q          <= id_d;
      cnt_q         <= cnt_d;
      ack_q         <= ack_d;
      err_q         <= err_d;
      done_q        <= done_d;
      long_wr_q     <= long_wr_d;
      long_mem_id_q <= long_mem_id_d;
      long_addr_q   <= long_addr_d;
      long_data_q   <= long_data_d;
      shrt_wr_q     <= shrt_wr_d;
      shrt_mem_id_q <= shrt_mem_id_d;
      shrt_addr_q   <= shrt_addr_d;
      shrt_data_q   <= shrt_data_d;
      tbl_valid_q   <= tbl_valid_d;
`ifdef CR_HUF_COMP_PH_LD_CHKSUM_EN
      xor_q         <= xor_d;
`endif
    end
  end

  assign ld_ack      = ack_q;
  assign ld_err      = err_q;
  assign ld_done     = done_q;
  assign ld_data_rdy = rdy;
  assign long_wr     = long_wr_q;
  assign long_mem_id = long_mem_id_q;
  assign long_addr   = long_addr_q;
  assign long_data   = long_data_q;
  assign shrt_wr     = shrt_wr_q;
  assign shrt_mem_id = shrt_mem_id_q;
  assign shrt_addr   = shrt_addr_q;
  assign shrt_data   = shrt_data_q;
  assign tbl_valid   = tbl_valid_q;

endmodule

// File: tb/tb_cr_huf_comp_ph_loader.sv
module tb_cr_huf_comp_ph_loader;

  localparam int NT = 10;
  localparam int DW = 60;
`ifdef CR_HUF_COMP_PH_LD_CHKSUM_EN
  localparam int NW = 71;
`else
  localparam int NW = 70;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ld_req = 1'b0;
  logic [3:0]    ld_mem_id = '0;
  logic          ld_ack;
  logic          ld_abort = 1'b0;
  logic [DW-1:0] ld_data = '0;
  logic          ld_data_val = 1'b0;
  logic          ld_data_rdy;
  logic [NT-1:0] tbl_in_use = '0;
  logic          long_wr;
  logic [3:0]    long_mem_id;
  logic [4:0]    long_addr;
  logic [DW-1:0] long_data;
  logic          shrt_wr;
  logic [3:0]    shrt_mem_id;
  logic [5:0]    shrt_addr;
  logic [DW-1:0] shrt_data;
  logic [NT-1:0] tbl_valid;
  logic          ld_done;
  logic          ld_err;

  cr_huf_comp_ph_loader dut (
    .clk(clk), .rst_n(rst_n),
    .ld_req(ld_req), .ld_mem_id(ld_mem_id), .ld_ack(ld_ack),
    .ld_abort(ld_abort),
    .ld_data(ld_data), .ld_data_val(ld_data_val), .ld_data_rdy(ld_data_rdy),
    .tbl_in_use(tbl_in_use),
    .long_wr(long_wr), .long_mem_id(long_mem_id), .long_addr(long_addr), .long_data(long_data),
    .shrt_wr(shrt_wr), .shrt_mem_id(shrt_mem_id), .shrt_addr(shrt_addr), .shrt_data(shrt_data),
    .tbl_valid(tbl_valid), .ld_done(ld_done), .ld_err(ld_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            addr;
    logic [DW-1:0] data;
    logic [3:0]    id;
    int            cyc;
  } wr_t;

  wr_t           lq[$];
  wr_t           sq[$];
  int            cyc_cnt = 0;
  int            n_ack = 0, n_err = 0, n_done = 0;
  int            ack_cyc = -1, err_cyc = -1;
  bit            both_wr = 0;
  int            n_checks = 0, n_fail = 0;
  logic [DW-1:0] words [NW];
  logic [NT-1:0] exp_valid = '0;

  // Write/pulse monitor, sampled on the falling edge away from the active edge.
  always @(negedge clk) begin
    wr_t w;
    cyc_cnt++;
    if (long_wr) begin
      w.addr = int'(long_addr); w.data = long_data; w.id = long_mem_id; w.cyc = cyc_cnt;
      lq.push_back(w);
    end
    if (shrt_wr) begin
      w.addr = int'(shrt_addr); w.data = shrt_data; w.id = shrt_mem_id; w.cyc = cyc_cnt;
      sq.push_back(w);
    end
    if (long_wr && shrt_wr) both_wr = 1;
    if (ld_ack)  begin n_ack++;  ack_cyc = cyc_cnt; end
    if (ld_err)  begin n_err++;  err_cyc = cyc_cnt; end
    if (ld_done) n_done++;
  end

  task automatic clear_mon();
    lq.delete(); sq.delete();
    n_ack = 0; n_err = 0; n_done = 0; ack_cyc = -1; err_cyc = -1;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Fills the table words; the checksum slot (if built) gets the XOR of the 70.
  task automatic fill_words(input bit rnd);
    logic [DW-1:0] x;
    x = '0;
    for (int i = 0; i < 70; i++) begin
      words[i] = rnd ? {$urandom, $urandom} : DW'(i);
      x ^= words[i];
    end
`ifdef CR_HUF_COMP_PH_LD_CHKSUM_EN
    words[70] = x;
`endif
  endtask

  task automatic request(input logic [3:0] id, output bit acked);
    int c;
    c = 0; acked = 0;
    ld_req = 1'b1; ld_mem_id = id;
    while (!acked && c < 50) begin
      @(negedge clk);
      if (ld_ack) acked = 1;
      else begin @(posedge clk); #1; c++; end
    end
    ld_req = 1'b0;
    @(posedge clk); #1;
  endtask

  // mode 0: val always high; 1: val pattern 1,0,0,1; 2: random val
  task automatic stream(input int n, input int mode, input int budget, output int got);
    int cyc;
    got = 0; cyc = 0;
    while (got < n && cyc < budget) begin
      ld_data = words[got];
      case (mode)
        0:       ld_data_val = 1'b1;
        1:       ld_data_val = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: ld_data_val = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      if (ld_data_val && ld_data_rdy) got++;
      @(posedge clk); #1;
      cyc++;
    end
    ld_data_val = 1'b0;
  endtask

  task automatic do_abort();
    ld_abort = 1'b1; ld_data_val = 1'b1; ld_data = '1;
    @(posedge clk); #1;
    ld_abort = 1'b0; ld_data_val = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({ld_ack, ld_err, ld_done, long_wr, shrt_wr, ld_data_rdy} !== 6'b0) begin
      n_fail++; $display("FAIL reset_pulses: got %b required 000000",
                         {ld_ack, ld_err, ld_done, long_wr, shrt_wr, ld_data_rdy});
    end
    n_checks++;
    if ({long_addr, shrt_addr, long_mem_id, shrt_mem_id} !== 19'b0 || long_data !== '0 || shrt_data !== '0) begin
      n_fail++; $display("FAIL reset_wrport: got addr %0d/%0d not all zero", long_addr, shrt_addr);
    end
    n_checks++;
    if (tbl_valid !== '0) begin
      n_fail++; $display("FAIL reset_valid: got %h required 0", tbl_valid);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    exp_valid = '0;
  endtask

  task automatic test_basic();
    bit acked; int got; int bad;
    clear_mon();
    fill_words(0);
    request(4'd3, acked);
    stream(NW, 0, 200, got);
    idle_cycles(3);
    exp_valid[3] = 1'b1;
    n_checks++;
    if (!acked || n_ack != 1) begin n_fail++; $display("FAIL basic_ack: got %0d acks required 1", n_ack); end
    n_checks++;
    if (lq.size() != 22 || sq.size() != 48) begin
      n_fail++; $display("FAIL basic_count: got %0d/%0d required 22/48", lq.size(), sq.size());
    end else begin
      bad = 0;
      for (int i = 0; i < 22; i++)
        if (lq[i].addr != i || lq[i].data !== DW'(i) || lq[i].id !== 4'd3 || lq[i].cyc != lq[0].cyc + i) bad++;
      n_checks++;
      if (bad != 0) begin n_fail++; $display("FAIL basic_long: got %0d bad writes required 0", bad); end
      bad = 0;
      for (int i = 0; i < 48; i++)
        if (sq[i].addr != i || sq[i].data !== DW'(22 + i) || sq[i].id !== 4'd3 || sq[i].cyc != lq[21].cyc + 1 + i) bad++;
      n_checks++;
      if (bad != 0) begin n_fail++; $display("FAIL basic_shrt: got %0d bad writes required 0", bad); end
    end
    n_checks++;
    if (n_done != 1 || n_err != 0) begin
      n_fail++; $display("FAIL basic_done: got done %0d err %0d required 1/0", n_done, n_err);
    end
    n_checks++;
    if (tbl_valid !== exp_valid) begin n_fail++; $display("FAIL basic_valid: got %h required %h", tbl_valid, exp_valid); end
    n_checks++;
    if (both_wr) begin n_fail++; $display("FAIL exclusive_wr: got both strobes high required never"); end
  endtask

  task automatic test_illegal_id();
    bit acked;
    clear_mon();
    request(4'd12, acked);
    idle_cycles(3);
    n_checks++;
    if (n_ack != 1 || n_err != 1 || ack_cyc != err_cyc) begin
      n_fail++; $display("FAIL illegal_ack_err: got ack %0d err %0d cyc %0d/%0d required 1/1 same", n_ack, n_err, ack_cyc, err_cyc);
    end
    n_checks++;
    if (lq.size() + sq.size() != 0 || ld_data_rdy !== 1'b0) begin
      n_fail++; $display("FAIL illegal_nowrite: got %0d writes rdy %b required 0/0", lq.size() + sq.size(), ld_data_rdy);
    end
    n_checks++;
    if (tbl_valid !== exp_valid) begin n_fail++; $display("FAIL illegal_valid: got %h required %h", tbl_valid, exp_valid); end
  endtask

  task automatic test_blocked();
    bit acked; int got; int rdy_seen;
    fill_words(1);
    request(4'd5, acked);
    stream(NW, 0, 200, got);
    idle_cycles(3);
    exp_valid[5] = 1'b1;
    n_checks++;
    if (tbl_valid !== exp_valid) begin n_fail++; $display("FAIL blocked_preload: got %h required %h", tbl_valid, exp_valid); end
    clear_mon();
    tbl_in_use[5] = 1'b1;
    request(4'd5, acked);
    exp_valid[5] = 1'b0;
    rdy_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ld_data_rdy !== 1'b0) rdy_seen++;
    end
    n_checks++;
    if (tbl_valid !== exp_valid) begin n_fail++; $display("FAIL blocked_cleared: got %h required %h", tbl_valid, exp_valid); end
    n_checks++;
    if (rdy_seen != 0) begin n_fail++; $display("FAIL blocked_rdy: got %0d ready cycles required 0", rdy_seen); end
    @(posedge clk); #1;
    tbl_in_use[5] = 1'b0;
    stream(NW, 0, 200, got);
    idle_cycles(3);
    exp_valid[5] = 1'b1;
    n_checks++;
    if (got != NW || lq.size() != 22 || sq.size() != 48 || tbl_valid !== exp_valid) begin
      n_fail++; $display("FAIL blocked_release: got %0d beats valid %h required %0d/%h", got, tbl_valid, NW, exp_valid);
    end
  endtask

  task automatic test_abort();
    bit acked; int got;
    clear_mon();
    fill_words(1);
    request(4'd7, acked);
    stream(30, 0, 100, got);
    do_abort();
    idle_cycles(5);
    n_checks++;
    if (lq.size() != 22 || sq.size() != 8 || (sq.size() == 8 && sq[7].addr != 7)) begin
      n_fail++; $display("FAIL abort_writes: got %0d/%0d required 22/8", lq.size(), sq.size());
    end
    n_checks++;
    if (n_err != 1 || n_done != 0 || ld_data_rdy !== 1'b0) begin
      n_fail++; $display("FAIL abort_err: got err %0d done %0d rdy %b required 1/0/0", n_err, n_done, ld_data_rdy);
    end
    n_checks++;
    if (tbl_valid !== exp_valid) begin n_fail++; $display("FAIL abort_valid: got %h required %h", tbl_valid, exp_valid); end
    clear_mon();
    request(4'd7, acked);
    stream(NW, 0, 200, got);
    idle_cycles(3);
    exp_valid[7] = 1'b1;
    n_checks++;
    if (lq.size() != 22 || sq.size() != 48 || lq[0].addr != 0 || sq[0].addr != 0 || lq[0].data !== words[0]) begin
      n_fail++; $display("FAIL abort_reload: got %0d/%0d writes required 22/48 from addr 0", lq.size(), sq.size());
    end
    n_checks++;
    if (tbl_valid !== exp_valid) begin n_fail++; $display("FAIL abort_reload_valid: got %h required %h", tbl_valid, exp_valid); end
  endtask

  task automatic test_gapped();
    bit acked; int got; int bad;
    clear_mon();
    fill_words(1);
    request(4'd1, acked);
    stream(NW, 1, 400, got);
    idle_cycles(3);
    exp_valid[1] = 1'b1;
    bad = 0;
    if (lq.size() == 22 && sq.size() == 48) begin
      for (int i = 0; i < 22; i++) if (lq[i].addr != i || lq[i].data !== words[i]) bad++;
      for (int i = 0; i < 48; i++) if (sq[i].addr != i || sq[i].data !== words[22 + i]) bad++;
    end else bad = 1000;
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL gapped_writes: got %0d/%0d writes %0d bad required 22/48 0", lq.size(), sq.size(), bad); end
    n_checks++;
    if (tbl_valid !== exp_valid || n_done != 1) begin
      n_fail++; $display("FAIL gapped_valid: got %h done %0d required %h/1", tbl_valid, n_done, exp_valid);
    end
  endtask

  task automatic test_random_back_to_back();
    bit acked; int got; int bad; int id; int k; bit ab;
    for (int it = 0; it < 8; it++) begin
      clear_mon();
      fill_words(1);
      id = $urandom_range(0, 11);
      ab = ($urandom_range(0, 2) == 0);
      k  = $urandom_range(0, 69);
      request(4'(id), acked);
      if (id >= NT) begin
        idle_cycles(2);
        n_checks++;
        if (n_err != 1 || lq.size() + sq.size() != 0 || tbl_valid !== exp_valid) begin
          n_fail++; $display("FAIL rand_illegal[%0d]: got err %0d valid %h required 1/%h", it, n_err, tbl_valid, exp_valid);
        end
      end else if (ab) begin
        stream(k, $urandom_range(0, 2), 600, got);
        do_abort();
        idle_cycles(2);
        exp_valid[id] = 1'b0;
        n_checks++;
        if (n_err != 1 || lq.size() != (k < 22 ? k : 22) || sq.size() != (k > 22 ? k - 22 : 0) || tbl_valid !== exp_valid) begin
          n_fail++; $display("FAIL rand_abort[%0d]: got %0d/%0d err %0d valid %h required k=%0d valid %h",
                             it, lq.size(), sq.size(), n_err, tbl_valid, k, exp_valid);
        end
      end else begin
        stream(NW, $urandom_range(0, 2), 600, got);
        idle_cycles(3);
        exp_valid[id] = 1'b1;
        bad = 0;
        if (lq.size() == 22 && sq.size() == 48) begin
          for (int i = 0; i < 22; i++) if (lq[i].addr != i || lq[i].data !== words[i] || lq[i].id !== 4'(id)) bad++;
          for (int i = 0; i < 48; i++) if (sq[i].addr != i || sq[i].data !== words[22 + i] || sq[i].id !== 4'(id)) bad++;
        end else bad = 1000;
        n_checks++;
        if (bad != 0 || n_done != 1 || tbl_valid !== exp_valid) begin
          n_fail++; $display("FAIL rand_load[%0d]: got %0d bad done %0d valid %h required 0/1/%h",
                             it, bad, n_done, tbl_valid, exp_valid);
        end
      end
    end
  endtask

  task automatic test_chksum();
    bit acked; int got;
`ifdef CR_HUF_COMP_PH_LD_CHKSUM_EN
    clear_mon();
    fill_words(1);
    request(4'd0, acked);
    stream(NW, 0, 200, got);
    idle_cycles(3);
    exp_valid[0] = 1'b1;
    n_checks++;
    if (tbl_valid !== exp_valid || n_done != 1 || lq.size() + sq.size() != 70) begin
      n_fail++; $display("FAIL chk_good: got valid %h done %0d writes %0d required %h/1/70", tbl_valid, n_done, lq.size() + sq.size(), exp_valid);
    end
    clear_mon();
    fill_words(1);
    words[70][0] = ~words[70][0];
    request(4'd9, acked);
    stream(NW, 0, 200, got);
    idle_cycles(3);
    exp_valid[9] = 1'b0;
    n_checks++;
    if (tbl_valid !== exp_valid || n_err != 1 || n_done != 0) begin
      n_fail++; $display("FAIL chk_bad: got valid %h err %0d done %0d required %h/1/0", tbl_valid, n_err, n_done, exp_valid);
    end
`else
    clear_mon();
    fill_words(1);
    request(4'd0, acked);
    stream(NW, 0, 200, got);
    stream(1, 0, 4, got);
    idle_cycles(2);
    exp_valid[0] = 1'b1;
    n_checks++;
    if (got != 0 || lq.size() + sq.size() != 70) begin
      n_fail++; $display("FAIL chk_off_extra: got %0d extra beats %0d writes required 0/70", got, lq.size() + sq.size());
    end
    n_checks++;
    if (tbl_valid !== exp_valid) begin n_fail++; $display("FAIL chk_off_valid: got %h required %h", tbl_valid, exp_valid); end
`endif
  endtask

  task automatic test_reset_midload();
    bit acked; int got;
    fill_words(1);
    request(4'd2, acked);
    stream(10, 0, 50, got);
    ld_data_val = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    clear_mon();
    n_checks++;
    if (tbl_valid !== '0 || long_wr !== 1'b0 || ld_data_rdy !== 1'b0) begin
      n_fail++; $display("FAIL midreset_state: got valid %h wr %b rdy %b required 0/0/0", tbl_valid, long_wr, ld_data_rdy);
    end
    exp_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(5);
    ld_data_val = 1'b0;
    n_checks++;
    if (lq.size() + sq.size() != 0 || tbl_valid !== exp_valid) begin
      n_fail++; $display("FAIL midreset_nowrite: got %0d writes valid %h required 0/0", lq.size() + sq.size(), tbl_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_illegal_id();
    test_blocked();
    test_abort();
    test_gapped();
    test_random_back_to_back();
    test_chksum();
    test_reset_midload();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
